alu_operand_stage: RTL

//  Operand-fetch stage sitting directly upstream of the 16-bit ALU (Ain/Bin/ALUop/out/Z).

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_operand_stage_if.sv | 59 +++++
 rtl/alu_regfile.sv | 45 ++++
 rtl/alu_operand_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the ALU operand-fetch stage: ALU opcodes,
//                B-operand shift codes and the fetch FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int c_OP_W    = 2;
    localparam int c_SHIFT_W = 2;

    // ALU opcode as presented on ALUop
    typedef enum logic [c_OP_W-1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        NOT = 2'b11
    } alu_op_e;

    // One-bit shift applied to the B operand
    typedef enum logic [c_SHIFT_W-1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    // Fetch sequence: accept, read A, read B, present to the ALU
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD_A = 2'b01,
        LOAD_B = 2'b10,
        ISSUE  = 2'b11
    } opnd_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage_if
//  Description : Bundle of the fetch-command channel, register-file write
//                port and ALU operand channel of alu_operand_stage.
//                master : command source / writeback / ALU side
//                slave  : the operand stage itself
//  Ports       : cmd_valid/cmd_ready/cmd_rn/cmd_rm/cmd_op/cmd_shift/
//                cmd_asel/cmd_bsel/cmd_imm, wr_en/wr_addr/wr_data,
//                alu_valid/alu_ready/Ain/Bin/ALUop
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
);
    localparam int ADDR_W = $clog2(NREGS);

    // fetch command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_rn;
    logic [ADDR_W-1:0] cmd_rm;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_shift;
    logic              cmd_asel;
    logic              cmd_bsel;
    logic [DATA_W-1:0] cmd_imm;

    // register-file write port
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // operand channel toward the ALU
    logic              alu_valid;
    logic              alu_ready;
    logic [DATA_W-1:0] Ain;
    logic [DATA_W-1:0] Bin;
    logic [1:0]        ALUop;

    modport master (
        output cmd_valid, cmd_rn, cmd_rm, cmd_op, cmd_shift,
               cmd_asel, cmd_bsel, cmd_imm,
        output wr_en, wr_addr, wr_data,
        output alu_ready,
        input  cmd_ready, alu_valid, Ain, Bin, ALUop
    );

    modport slave (
        input  cmd_valid, cmd_rn, cmd_rm, cmd_op, cmd_shift,
               cmd_asel, cmd_bsel, cmd_imm,
        input  wr_en, wr_addr, wr_data,
        input  alu_ready,
        output cmd_ready, alu_valid, Ain, Bin, ALUop
    );

endinterface : alu_operand_stage_if
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_regfile
//  Description : NREGS x DATA_W register file, two asynchronous read ports,
//                one synchronous write port. Reads are write-first: a read of
//                the index being written in the same cycle returns the new
//                data. Synchronous active-low clear of every entry.
//  Ports       : clk, rst_n, we/waddr/wdata, raddr_a/rdata_a, raddr_b/rdata_b
//  Revision    : 1.0  initial release
// ============================================================================
module alu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr_a,
    output      logic [DATA_W-1:0] rdata_a,
    input  wire logic [ADDR_W-1:0] raddr_b,
    output      logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Bypass the array when the write targets the index being read, so the
    // fetch stage sees the value the writeback stage is committing this cycle.
    assign rdata_a = (we && (waddr == raddr_a)) ? wdata : r_mem[raddr_a];
    assign rdata_b = (we && (waddr == raddr_b)) ? wdata : r_mem[raddr_b];

endmodule : alu_regfile
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : Operand-fetch stage in front of the 16-bit ALU. Accepts a
//                fetch command, reads A then B from the register file
//                (optionally forcing A to zero, substituting an immediate for
//                B and shifting B by one), and presents Ain/Bin/ALUop under a
//                valid/ready handshake. The write port is live in every state.
//  Ports       : clk    rising-edge clock
//                rst_n  synchronous active-low reset (aborts any command)
//                bus    alu_operand_stage_if.slave (command, write, ALU side)
//  Config      : ALU_OPND_SHIFTER_EN defined   -> one-bit shifter in B path
//                ALU_OPND_SHIFTER_EN undefined -> cmd_shift ignored
//  Revision    : 1.0  initial release
// ============================================================================
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_operand_stage_if.slave bus
);

    localparam int ADDR_W = $clog2(NREGS);

    opnd_state_e       r_state;
    opnd_state_e       w_state_nxt;
    logic              w_accept;

    // captured command
    logic [ADDR_W-1:0] r_rn;
    logic [ADDR_W-1:0] r_rm;
    alu_op_e           r_op;
    logic              r_asel;
    logic              r_bsel;
    logic [DATA_W-1:0] r_imm;

    // operand registers, driven straight onto Ain/Bin
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_alu_valid;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_b_pre;
    logic [DATA_W-1:0] w_b_post;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (bus.wr_en),
        .waddr   (bus.wr_addr),
        .wdata   (bus.wr_data),
        .raddr_a (r_rn),
        .rdata_a (w_rd_a),
        .raddr_b (r_rm),
        .rdata_b (w_rd_b)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LOAD_A;
                end
            end
            LOAD_A: w_state_nxt = LOAD_B;
            LOAD_B: w_state_nxt = ISSUE;
            ISSUE: begin
                if (r_alu_valid && bus.alu_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Held low during reset so no command is taken while the stage clears.
    assign bus.cmd_ready = rst_n && (r_state == IDLE);

    // ------------------------------------------------------------------
    // Command capture: later changes on cmd_* have no effect
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rn   <= '0;
            r_rm   <= '0;
            r_op   <= ADD;
            r_asel <= 1'b0;
            r_bsel <= 1'b0;
            r_imm  <= '0;
        end else if (w_accept) begin
            r_rn   <= bus.cmd_rn;
            r_rm   <= bus.cmd_rm;
            r_op   <= alu_op_e'(bus.cmd_op);
            r_asel <= bus.cmd_asel;
            r_bsel <= bus.cmd_bsel;
            r_imm  <= bus.cmd_imm;
        end
    end

    // ------------------------------------------------------------------
    // B operand path
    // ------------------------------------------------------------------
    assign w_b_pre = r_bsel ? r_imm : w_rd_b;

`ifdef ALU_OPND_SHIFTER_EN
    shift_e r_shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= SH_NONE;
        end else if (w_accept) begin
            r_shift <= shift_e'(bus.cmd_shift);
        end
    end

    always_comb begin
        w_b_post = w_b_pre;
        case (r_shift)
            SH_NONE: w_b_post = w_b_pre;
            SH_LSL1: w_b_post = {w_b_pre[DATA_W-2:0], 1'b0};
            SH_LSR1: w_b_post = {1'b0, w_b_pre[DATA_W-1:1]};
            SH_ASR1: w_b_post = {w_b_pre[DATA_W-1], w_b_pre[DATA_W-1:1]};
            default: w_b_post = w_b_pre;
        endcase
    end
`else
    // Shift code is accepted on the interface but has no effect.
    logic w_unused_shift;
    assign w_unused_shift = ^bus.cmd_shift;
    assign w_b_post       = w_b_pre;
`endif

    // ------------------------------------------------------------------
    // Operand registers and ALU handshake
    // ------------------------------------------------------------------
    // alu_valid rises on the first ISSUE cycle, so it is seen three edges
    // after the accepting edge. Operands are only loaded in LOAD_A/LOAD_B,
    // so they are frozen for the whole ISSUE state regardless of how long
    // the ALU holds off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_alu_valid <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: r_a <= r_asel ? '0 : w_rd_a;
                LOAD_B: r_b <= w_b_post;
                ISSUE: begin
                    if (!r_alu_valid) begin
                        r_alu_valid <= 1'b1;
                    end else if (bus.alu_ready) begin
                        r_alu_valid <= 1'b0;
                    end
                end
                default: r_alu_valid <= 1'b0;
            endcase
        end
    end

    assign bus.alu_valid = r_alu_valid;
    assign bus.Ain       = r_a;
    assign bus.Bin       = r_b;
    assign bus.ALUop     = r_op;

endmodule : alu_operand_stage
`default_nettype wire
